// File: rtl/sao_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | sao_pkg : shared band-offset statistic types and width helpers
// | rev 1.0
// +----------------------------------------------------------------------------
package sao_pkg;

  localparam int N_BO_BANDS = 32;

  // A CTB holds at most 2^(2*ctb_log2) pixels, so the count needs one extra bit.
  function automatic int cnt_width(input int ctb_log2);
    return 2 * ctb_log2 + 1;
  endfunction

  function automatic int sum_width(input int bit_depth, input int ctb_log2);
    return bit_depth + 2 * ctb_log2 + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DUMP = 2'd2
  } bo_acc_state_t;

endpackage
`default_nettype wire

// File: rtl/sao_stat_bo_band_sum.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | sao_stat_bo_band_sum : per-beat hit count and diff sum for one band
// | rev 1.0
// +----------------------------------------------------------------------------
module sao_stat_bo_band_sum #(
  parameter int N_PIX     = 4,
  parameter int N_BO_TYPE = 5,
  parameter int DIFF_W    = 9,
  parameter int CNT_W     = 13,
  parameter int SUM_W     = 21,
  parameter int BAND      = 0
) (
  input  logic [N_PIX*N_BO_TYPE-1:0] bo_cate,
  input  logic [N_PIX*DIFF_W-1:0]    n_diff,
  input  logic [N_PIX-1:0]           pix_en,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [SUM_W-1:0]           hit_sum
);

  localparam logic [N_BO_TYPE-1:0] BAND_ID = N_BO_TYPE'(BAND);

  logic [DIFF_W-1:0] diff_i;
  logic [CNT_W-1:0]  cnt_acc;
  logic [SUM_W-1:0]  sum_acc;

  always_comb begin
    cnt_acc = '0;
    sum_acc = '0;
    diff_i  = '0;
    for (int i = 0; i < N_PIX; i++) begin
      diff_i = n_diff[i*DIFF_W +: DIFF_W];
      if (pix_en[i] && (bo_cate[i*N_BO_TYPE +: N_BO_TYPE] == BAND_ID)) begin
        cnt_acc = cnt_acc + CNT_W'(1);
        sum_acc = sum_acc + {{(SUM_W-DIFF_W){diff_i[DIFF_W-1]}}, diff_i};
      end
    end
  end

  assign hit_cnt = cnt_acc;
  assign hit_sum = sum_acc;

endmodule
`default_nettype wire

// File: rtl/sao_stat_bo_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | sao_stat_bo_accum : per-CTB band-offset count/sum accumulator and drain.
// | Optional SAO_BO_PIX_MASK_EN adds pix_mask to exclude pixels. rev 1.0
// +----------------------------------------------------------------------------
module sao_stat_bo_accum
  import sao_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int N_PIX     = 4,
  parameter int N_BO_TYPE = 5,
  parameter int CTB_LOG2  = 6
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_last,
  input  logic [N_PIX*N_BO_TYPE-1:0]            bo_cate,
  input  logic [N_PIX*(BIT_DEPTH+1)-1:0]        n_diff,
`ifdef SAO_BO_PIX_MASK_EN
  input  logic [N_PIX-1:0]                      pix_mask,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [N_BO_TYPE-1:0]                  out_band,
  output logic [2*CTB_LOG2:0]                   out_cnt,
  output logic [BIT_DEPTH+2*CTB_LOG2:0]         out_sum,
  output logic                                  ctb_done
);

  localparam int DIFF_W = BIT_DEPTH + 1;
  localparam int CNT_W  = cnt_width(CTB_LOG2);
  localparam int SUM_W  = sum_width(BIT_DEPTH, CTB_LOG2);
  localparam logic [N_BO_TYPE-1:0] LAST_BAND = N_BO_TYPE'(N_BO_BANDS - 1);

  bo_acc_state_t        state_q, state_d;
  logic [N_BO_TYPE-1:0] band_q, band_d;
  logic                 ctb_done_q, ctb_done_d;
  logic [CNT_W-1:0]     cnt_q [N_BO_BANDS];
  logic [CNT_W-1:0]     cnt_d [N_BO_BANDS];
  logic [SUM_W-1:0]     sum_q [N_BO_BANDS];
  logic [SUM_W-1:0]     sum_d [N_BO_BANDS];
  logic [CNT_W-1:0]     hit_cnt [N_BO_BANDS];
  logic [SUM_W-1:0]     hit_sum [N_BO_BANDS];
  logic [N_PIX-1:0]     pix_en;
  logic                 accept, out_hs, last_hs;

`ifdef SAO_BO_PIX_MASK_EN
  assign pix_en = pix_mask;
`else
  assign pix_en = '1;
`endif

  for (genvar b = 0; b < N_BO_BANDS; b++) begin : g_band
    sao_stat_bo_band_sum #(
      .N_PIX    (N_PIX),
      .N_BO_TYPE(N_BO_TYPE),
      .DIFF_W   (DIFF_W),
      .CNT_W    (CNT_W),
      .SUM_W    (SUM_W),
      .BAND     (b)
    ) u_band_sum (
      .bo_cate(bo_cate),
      .n_diff (n_diff),
      .pix_en (pix_en),
      .hit_cnt(hit_cnt[b]),
      .hit_sum(hit_sum[b])
    );
  end

  assign in_ready  = (state_q != DUMP);
  assign out_valid = (state_q == DUMP);
  assign out_band  = band_q;
  assign out_cnt   = cnt_q[band_q];
  assign out_sum   = sum_q[band_q];
  assign ctb_done  = ctb_done_q;

  assign accept  = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign last_hs = out_hs && (band_q == LAST_BAND);

  always_comb begin
    state_d    = state_q;
    band_d     = band_q;
    ctb_done_d = 1'b0;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    case (state_q)
      IDLE, ACC: if (accept) state_d = in_last ? DUMP : ACC;
      DUMP: begin
        if (last_hs) begin
          state_d    = IDLE;
          band_d     = '0;
          ctb_done_d = 1'b1;
        end else if (out_hs) begin
          band_d = band_q + N_BO_TYPE'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Accept and final drain handshake are mutually exclusive (in_ready is low in DUMP).
    for (int b = 0; b < N_BO_BANDS; b++) begin
      if (accept) begin
        cnt_d[b] = cnt_q[b] + hit_cnt[b];
        sum_d[b] = sum_q[b] + hit_sum[b];
      end else if (last_hs) begin
        cnt_d[b] = '0;
        sum_d[b] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      band_q     <= '0;
      ctb_done_q <= 1'b0;
      for (int b = 0; b < N_BO_BANDS; b++) begin
        cnt_q[b] <= '0;
        sum_q[b] <= '0;
      end
    end else begin
      state_q    <= state_d;
      band_q     <= band_d;
      ctb_done_q <= ctb_done_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sao_stat_bo_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_sao_stat_bo_accum : scoreboard bench for the band-offset accumulator
// | rev 1.0
// +----------------------------------------------------------------------------
module tb_sao_stat_bo_accum;

  localparam int CNT_W = 13;
  localparam int SUM_W = 21;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [19:0] bo_cate = '0;
  logic [35:0] n_diff = '0;
`ifdef SAO_BO_PIX_MASK_EN
  logic [3:0]  pix_mask = 4'hF;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_band;
  logic [CNT_W-1:0] out_cnt;
  logic [SUM_W-1:0] out_sum;
  logic        ctb_done;

  typedef struct {
    int band;
    int cnt;
    int sum;
  } exp_t;

  exp_t sb[$];
  int   m_cnt [32];
  int   m_sum [32];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sao_stat_bo_accum dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .bo_cate  (bo_cate),
    .n_diff   (n_diff),
`ifdef SAO_BO_PIX_MASK_EN
    .pix_mask (pix_mask),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_band (out_band),
    .out_cnt  (out_cnt),
    .out_sum  (out_sum),
    .ctb_done (ctb_done)
  );

  function automatic logic [19:0] mk_cate(input int c3, input int c2, input int c1, input int c0);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  function automatic logic [35:0] mk_diff(input int d3, input int d2, input int d1, input int d0);
    return {9'(d3), 9'(d2), 9'(d1), 9'(d0)};
  endfunction

  task automatic clear_model();
    for (int b = 0; b < 32; b++) begin
      m_cnt[b] = 0;
      m_sum[b] = 0;
    end
  endtask

  task automatic send_beat(input logic [19:0] cate, input logic [35:0] diff,
                           input logic [3:0] mask, input logic last);
    int n = 0;
    logic [3:0] eff;
    logic signed [8:0] ds;
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = last;
    bo_cate  = cate;
    n_diff   = diff;
`ifdef SAO_BO_PIX_MASK_EN
    pix_mask = mask;
    eff = mask;
`else
    eff = 4'hF;
`endif
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (eff[i]) begin
        ds = diff[i*9 +: 9];
        m_cnt[cate[i*5 +: 5]] += 1;
        m_sum[cate[i*5 +: 5]] += int'(ds);
      end
    end
  endtask

  task automatic push_ctb();
    for (int b = 0; b < 32; b++) sb.push_back('{band: b, cnt: m_cnt[b], sum: m_sum[b]});
    clear_model();
  endtask

  // Drain 32 bands from the scoreboard, optionally stalling out_ready at one band.
  task automatic drain(input int stall_band, input int stall_n);
    int got = 0;
    int budget = 0;
    int left = stall_n;
    logic [4:0] s_band;
    logic [CNT_W-1:0] s_cnt;
    logic [SUM_W-1:0] s_sum;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_band !== 5'd0) begin
      $display("FAIL drain_latency: out_valid=%b out_band=%0d required 1/0", out_valid, out_band);
    end else n_pass++;
    while (got < 32 && budget < 300) begin
      if (out_valid === 1'b1) begin
        if (left > 0 && out_band == 5'(stall_band)) begin
          out_ready = 1'b0;
          if (left == stall_n) begin
            s_band = out_band;
            s_cnt  = out_cnt;
            s_sum  = out_sum;
          end else begin
            n_checks++;
            if (out_band !== s_band || out_cnt !== s_cnt || out_sum !== s_sum || in_ready !== 1'b0) begin
              $display("FAIL stall_hold: band=%0d cnt=%0d sum=%0h in_ready=%b required %0d/%0d/%0h/0",
                       out_band, out_cnt, out_sum, in_ready, s_band, s_cnt, s_sum);
            end else n_pass++;
          end
          left--;
        end else begin
          out_ready = 1'b1;
          n_checks++;
          if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: band=%0d required none", out_band);
          end else begin
            e = sb.pop_front();
            if (out_band !== 5'(e.band) || out_cnt !== CNT_W'(e.cnt) || out_sum !== SUM_W'(e.sum)) begin
              $display("FAIL band_stat: band=%0d cnt=%0d sum=%0h required %0d/%0d/%0h",
                       out_band, out_cnt, out_sum, e.band, CNT_W'(e.cnt), SUM_W'(e.sum));
            end else n_pass++;
          end
          got++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    if (got < 32) begin
      n_checks++;
      $display("FAIL drain_timeout: handshakes=%0d required 32", got);
    end
    n_checks++;
    if (ctb_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL ctb_done_pulse: done=%b valid=%b in_ready=%b required 1/0/1", ctb_done, out_valid, in_ready);
    end else n_pass++;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctb_done !== 1'b0) begin
      $display("FAIL ctb_done_width: done=%b required 0", ctb_done);
    end else n_pass++;
  endtask

  task automatic test_reset();
    #23 arst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_band !== 5'd0 ||
        out_cnt !== '0 || out_sum !== '0 || ctb_done !== 1'b0) begin
      $display("FAIL reset_state: rdy=%b val=%b band=%0d cnt=%0d sum=%0h done=%b required 1/0/0/0/0/0",
               in_ready, out_valid, out_band, out_cnt, out_sum, ctb_done);
    end else n_pass++;
  endtask

  task automatic test_single_beat();
    send_beat(mk_cate(3, 3, 3, 3), mk_diff(0, 5, -2, 1), 4'hF, 1'b1);
    push_ctb();
    drain(-1, 0);
  endtask

  task automatic test_back_to_back();
    send_beat(mk_cate(9, 9, 7, 7), mk_diff(10, 10, 10, 10), 4'hF, 1'b0);
    send_beat(mk_cate(7, 7, 9, 9), mk_diff(10, 10, 10, 10), 4'hF, 1'b1);
    push_ctb();
    drain(-1, 0);
  endtask

  task automatic test_distinct_bands();
    send_beat(mk_cate(31, 20, 10, 0), mk_diff(100, -1, 255, -256), 4'hF, 1'b0);
    send_beat(mk_cate(0, 12, 12, 31), mk_diff(-7, 33, -40, 1), 4'hF, 1'b1);
    push_ctb();
    drain(-1, 0);
  endtask

  task automatic test_backpressure();
    send_beat(mk_cate(12, 12, 11, 13), mk_diff(-3, 8, 2, 4), 4'hF, 1'b1);
    push_ctb();
    drain(12, 6);
  endtask

  task automatic test_full_ctb();
    for (int k = 0; k < 1024; k++)
      send_beat(mk_cate(31, 31, 31, 31), mk_diff(-256, -256, -256, -256), 4'hF, (k == 1023));
    push_ctb();
    drain(-1, 0);
  endtask

  task automatic test_reset_mid_dump();
    int n = 0;
    send_beat(mk_cate(0, 0, 5, 0), mk_diff(7, 7, 7, 7), 4'hF, 1'b1);
    push_ctb();
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    while (out_band !== 5'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    n_checks++;
    if (n >= 100 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_band !== 5'd0 ||
        out_cnt !== '0 || out_sum !== '0 || ctb_done !== 1'b0) begin
      $display("FAIL async_reset: wait=%0d rdy=%b val=%b band=%0d cnt=%0d sum=%0h done=%b required 1/0/0/0/0/0",
               n, in_ready, out_valid, out_band, out_cnt, out_sum, ctb_done);
    end else n_pass++;
    sb.delete();
    @(negedge clk);
    arst_n = 1'b1;
    send_beat(mk_cate(0, 0, 0, 0), mk_diff(1, 1, 1, 1), 4'hF, 1'b1);
    push_ctb();
    drain(-1, 0);
  endtask

`ifdef SAO_BO_PIX_MASK_EN
  task automatic test_pix_mask();
    send_beat(mk_cate(2, 2, 2, 2), mk_diff(3, 3, 3, 3), 4'b0101, 1'b1);
    push_ctb();
    drain(-1, 0);
    send_beat(mk_cate(4, 4, 4, 4), mk_diff(9, 9, 9, 9), 4'b0000, 1'b1);
    push_ctb();
    drain(-1, 0);
  endtask
`endif

  initial begin
    clear_model();
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_distinct_bands();
    test_backpressure();
    test_full_ctb();
    test_reset_mid_dump();
`ifdef SAO_BO_PIX_MASK_EN
    test_pix_mask();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sao_stat_bo_accum.md
Name: sao_stat_bo_accum

Overview:
Downstream of the per-pixel band-offset classifier. Consumes, per beat, n_pix band categories plus n_pix signed (org - rec) differences. Accumulates per-band pixel count and difference sum over one CTB, then drains the 32 band statistics one band per cycle to the SAO rate-distortion/offset-decision stage over a valid/ready handshake.

Parameters:
bit_depth, 8, sample bit depth; diff width is bit_depth+1, signed
n_pix, 4, pixels per input beat
n_bo_type, 5, band category width (32 bands)
ctb_log2, 6, log2 CTB size; bounds the per-CTB pixel count at 2^(2*ctb_log2)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_last  in  1  last beat of current CTB
bo_cate  in  n_bo_type x n_pix  band category per pixel, from classifier
n_diff  in  (bit_depth+1) x n_pix  signed org-rec per pixel
pix_mask  in  n_pix  per-pixel include flag (only with SAO_BO_PIX_MASK_EN)
out_valid  out  1  band statistic valid
out_ready  in  1  downstream accepts
out_band  out  n_bo_type  band index 0..31
out_cnt  out  2*ctb_log2+1  pixel count in band
out_sum  out  bit_depth+2*ctb_log2+1  signed diff sum in band
ctb_done  out  1  one-cycle pulse after band 31 handshakes

Behaviour:
- Reset is asynchronous and active-low on arst_n, clocked by clk. Reset state: IDLE, all accumulators 0, in_ready=1, out_valid=0, out_band=0, out_cnt=0, out_sum=0, ctb_done=0.
- FSM states: IDLE, ACC, DUMP.
  - IDLE: an accepted beat goes to ACC, or to DUMP if in_last=1.
  - ACC: an accepted beat with in_last=1 goes to DUMP.
  - DUMP: stays until band 31 handshakes, then returns to IDLE.
- in_ready = (state != DUMP). No input is accepted while draining.
- Accumulation on an accepted beat, for each band b:
  - cnt[b] += number of pixels i with bo_cate[i]==b.
  - sum[b] += sign-extended sum of n_diff[i] over those pixels.
  - Several pixels in one beat may hit the same band; all are counted.
- Registers update at the accepting edge.
- Latency: the last beat is accepted at cycle t; out_valid=1 at t+1 with band 0, including the last beat's contribution.
- DUMP:
  - out_valid=1. out_band = drain counter; out_cnt/out_sum are the registered values of that band.
  - Counter advances on out_valid && out_ready. Outputs are held stable while out_ready=0.
  - Handshake on band 31: all accumulators and the counter clear to 0, ctb_done pulses for 1 cycle, state returns to IDLE, out_valid=0 the next cycle.
- Arithmetic:
  - Widths are sized so no overflow occurs for up to 2^(2*ctb_log2) pixels per CTB.
  - Exceeding that wraps modulo 2^width and is not flagged.
- Empty bands drain with cnt=0, sum=0; every CTB always drains all 32 bands.
- Asynchronous reset mid-ACC or mid-DUMP discards all partial statistics and returns to the reset state. No ctb_done is issued for the interrupted CTB.

Optional Feature:
- SAO_BO_PIX_MASK_EN defined:
  - The pix_mask port exists.
  - Pixels with pix_mask[i]=0 contribute to neither cnt nor sum (picture-boundary or unavailable pixels).
  - An all-zero mask beat is still accepted and still honours in_last.
- Undefined: the pix_mask port is absent and all n_pix pixels are always counted.

Decomposition:
- sao_pkg holds:
  - N_BO_BANDS=32
  - width functions/localparams for cnt and sum derived from bit_depth, ctb_log2
  - typedef enum {IDLE, ACC, DUMP} bo_acc_state_t
- Sub-module sao_stat_bo_band_sum: combinational reduction of one band's n_pix matches (hit count + sign-extended diff sum, mask-aware). Instantiated 32 times with generate.

Test Plan:
1. Single-beat CTB: in_last=1, cate={3,3,3,3}, diff={+1,-2,+5,0} -> band 3 cnt=4 sum=+4; other 31 bands cnt=0 sum=0; ctb_done after 32 handshakes.
2. Same-band collision across beats: 2 beats, cate={7,7,9,9}, diff=+10 each -> band 7 cnt=4 sum=+40; band 9 cnt=4 sum=+40.
3. Backpressure: out_ready=0 for 5 cycles at band 12 -> out_band/out_cnt/out_sum stable, in_ready=0 throughout; drain resumes on out_ready=1.
4. Full 64x64 CTB, 1024 beats, all cate=31, diff=-256 -> band 31 cnt=4096 sum=-1048576, no wrap.
5. Reset mid-DUMP at band 5, then new single-beat CTB cate={0,0,0,0}, diff=+1 -> band 0 cnt=4 sum=+4; no residue from the prior CTB.
6. SAO_BO_PIX_MASK_EN, mask=4'b0101, cate={2,2,2,2}, diff={+3,+3,+3,+3} -> band 2 cnt=2 sum=+6.
